// File: rtl/cache_pkg.sv
// Shared types and helpers for the line-refill cache controller.
package cache_pkg;

  localparam int ADDR_W_DEF = 15;
  localparam int CNT_W_DEF  = 16;

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    LOOKUP,
    REFILL,
    COMMIT
  } state_t;

  // Word-offset width; a one-word line still carries a 1-bit index.
  function automatic int off_w(input int line_words);
    return (line_words <= 1) ? 1 : $clog2(line_words);
  endfunction

endpackage

// File: rtl/cache_line_ctrl_sat_counter.sv
// Saturating statistics counter with synchronous clear taking priority.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 cnt <= '0;
    else if (clr)               cnt <= '0;
    else if (inc && cnt != '1)  cnt <= cnt + CNT_W'(1);
  end

endmodule

// File: rtl/cache_line_ctrl.sv
// Direct-mapped cache line controller: lookup, multi-beat refill, tag commit
// and saturating access/hit/miss statistics.
module cache_line_ctrl
  import cache_pkg::*;
#(
  parameter int  ADDR_W     = ADDR_W_DEF,
  parameter int  LINE_WORDS = 4,
  parameter int  CNT_W      = CNT_W_DEF,
  localparam int OFF_W      = off_w(LINE_WORDS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              done,
  input  logic              req_valid,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic              req_last,
  output logic              req_ready,
  input  logic              hit,
  output logic              resp_valid,
  output logic              resp_hit,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_valid,
  output logic              wr_en,
  output logic [OFF_W-1:0]  wr_word,
  output logic              tag_wr,
  input  logic              clr_stats,
  output logic [CNT_W-1:0]  acc_cnt,
  output logic [CNT_W-1:0]  hit_cnt,
  output logic [CNT_W-1:0]  miss_cnt
);

  localparam logic [OFF_W-1:0]  LAST_BEAT = OFF_W'(LINE_WORDS - 1);
  localparam logic [ADDR_W-1:0] LINE_MSK  = ~ADDR_W'(LINE_WORDS - 1);

  state_t            state;
  logic [ADDR_W-1:0] cap_addr;   // line base: offset bits cleared at capture
  logic              cap_last;
  logic [OFF_W-1:0]  beat;
  logic              rsp_hit_q;
  logic              acc;

  assign acc = req_valid && (state == LOOKUP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cap_addr  <= '0;
      cap_last  <= 1'b0;
      beat      <= '0;
      rsp_hit_q <= 1'b0;
    end else begin
      rsp_hit_q <= 1'b0;
      case (state)
        IDLE:   if (start) state <= ARM;
        ARM:    if (!start) state <= LOOKUP;
        LOOKUP: if (req_valid) begin
          if (hit) begin
            rsp_hit_q <= 1'b1;
            if (req_last) state <= IDLE;
          end else begin
            cap_addr <= req_addr & LINE_MSK;
            cap_last <= req_last;
            beat     <= '0;
            state    <= REFILL;
          end
        end
        REFILL: if (mem_valid) begin
          if (beat == LAST_BEAT) begin
            beat  <= '0;
            state <= COMMIT;
          end else begin
            beat <= beat + OFF_W'(1);
          end
        end
        COMMIT: state <= cap_last ? IDLE : LOOKUP;
        default: state <= IDLE;
      endcase
    end
  end

  assign done       = (state == IDLE);
  assign req_ready  = (state == LOOKUP);
  assign mem_rd     = (state == REFILL);
  assign mem_addr   = cap_addr | ADDR_W'(beat);
  assign wr_en      = (state == REFILL) && mem_valid;
  assign wr_word    = beat;
  assign tag_wr     = (state == COMMIT);
  assign resp_valid = rsp_hit_q || (state == COMMIT);
  assign resp_hit   = rsp_hit_q;

  sat_counter #(.CNT_W(CNT_W)) u_acc (
    .clk(clk), .rst_n(rst_n), .inc(acc),         .clr(clr_stats), .cnt(acc_cnt)
  );
  sat_counter #(.CNT_W(CNT_W)) u_hit (
    .clk(clk), .rst_n(rst_n), .inc(acc && hit),  .clr(clr_stats), .cnt(hit_cnt)
  );
  sat_counter #(.CNT_W(CNT_W)) u_miss (
    .clk(clk), .rst_n(rst_n), .inc(acc && !hit), .clr(clr_stats), .cnt(miss_cnt)
  );

endmodule

// File: tb/tb_cache_line_ctrl.sv
// Directed bench: a 4-word-line / 4-bit-counter instance and a 1-word-line instance.
module tb_cache_line_ctrl;

  localparam int AW = 15;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // instance a: LINE_WORDS=4, CNT_W=4
  logic          start, done, req_valid, req_last, req_ready, hit;
  logic [AW-1:0] req_addr, mem_addr;
  logic          resp_valid, resp_hit, mem_rd, mem_valid, wr_en, tag_wr, clr_stats;
  logic [1:0]    wr_word;
  logic [3:0]    acc_cnt, hit_cnt, miss_cnt;

  // instance b: LINE_WORDS=1, CNT_W=16
  logic          b_start, b_done, b_req_valid, b_req_last, b_req_ready, b_hit;
  logic [AW-1:0] b_req_addr, b_mem_addr;
  logic          b_resp_valid, b_resp_hit, b_mem_rd, b_mem_valid, b_wr_en, b_tag_wr;
  logic [0:0]    b_wr_word;
  logic [15:0]   b_acc_cnt, b_hit_cnt, b_miss_cnt;

  cache_line_ctrl #(.ADDR_W(AW), .LINE_WORDS(4), .CNT_W(4)) u_a (
    .clk(clk), .rst_n(rst_n), .start(start), .done(done),
    .req_valid(req_valid), .req_addr(req_addr), .req_last(req_last), .req_ready(req_ready),
    .hit(hit), .resp_valid(resp_valid), .resp_hit(resp_hit),
    .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_valid(mem_valid),
    .wr_en(wr_en), .wr_word(wr_word), .tag_wr(tag_wr), .clr_stats(clr_stats),
    .acc_cnt(acc_cnt), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  cache_line_ctrl #(.ADDR_W(AW), .LINE_WORDS(1), .CNT_W(16)) u_b (
    .clk(clk), .rst_n(rst_n), .start(b_start), .done(b_done),
    .req_valid(b_req_valid), .req_addr(b_req_addr), .req_last(b_req_last), .req_ready(b_req_ready),
    .hit(b_hit), .resp_valid(b_resp_valid), .resp_hit(b_resp_hit),
    .mem_rd(b_mem_rd), .mem_addr(b_mem_addr), .mem_valid(b_mem_valid),
    .wr_en(b_wr_en), .wr_word(b_wr_word), .tag_wr(b_tag_wr), .clr_stats(1'b0),
    .acc_cnt(b_acc_cnt), .hit_cnt(b_hit_cnt), .miss_cnt(b_miss_cnt)
  );

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic go_lookup;
    start = 1'b1; tick;
    start = 1'b0; tick;
  endtask

  initial begin
    rst_n = 1'b0;
    {start, req_valid, req_last, hit, mem_valid, clr_stats} = '0;
    req_addr = '0;
    {b_start, b_req_valid, b_req_last, b_hit, b_mem_valid} = '0;
    b_req_addr = '0;
    repeat (2) tick;

    // reset state
    chk("rst_done", done, 1);
    chk("rst_ready", req_ready, 0);
    chk("rst_resp", resp_valid, 0);
    chk("rst_memrd", mem_rd, 0);
    chk("rst_memaddr", mem_addr, 0);
    chk("rst_tagwr", tag_wr, 0);
    chk("rst_acc", acc_cnt, 0);
    rst_n = 1'b1; tick;

    // start held high stays in ARM
    start = 1'b1; tick; tick;
    chk("arm_hold_ready", req_ready, 0);
    chk("arm_hold_done", done, 0);
    start = 1'b0; tick;
    chk("lookup_ready", req_ready, 1);

    // two back-to-back hits
    req_valid = 1'b1; hit = 1'b1; req_addr = 15'h0010; req_last = 1'b0; tick;
    chk("hit1_resp", resp_valid, 1);
    chk("hit1_rhit", resp_hit, 1);
    req_addr = 15'h0011; req_last = 1'b1; tick;
    chk("hit2_resp", resp_valid, 1);
    chk("hit2_done", done, 1);
    req_valid = 1'b0; req_last = 1'b0; tick;
    chk("hit_resp_end", resp_valid, 0);
    chk("hit_acc", acc_cnt, 2);
    chk("hit_hit", hit_cnt, 2);
    chk("hit_miss", miss_cnt, 0);

    // miss on 0x1236 with 2-cycle gaps between beats
    go_lookup;
    req_valid = 1'b1; hit = 1'b0; req_addr = 15'h1236; req_last = 1'b1; tick;
    req_valid = 1'b0; req_last = 1'b0;
    chk("miss_memrd", mem_rd, 1);
    chk("miss_ready", req_ready, 0);
    for (int k = 0; k < 4; k++) begin
      tick; tick;
      chk("beat_addr", mem_addr, 32'h1234 + k);
      chk("beat_gap_wr", wr_en, 0);
      mem_valid = 1'b1; #1;
      chk("beat_wr", wr_en, 1);
      chk("beat_word", wr_word, k);
      chk("beat_tag", tag_wr, 0);
      tick;
      mem_valid = 1'b0;
    end
    chk("commit_tag", tag_wr, 1);
    chk("commit_resp", resp_valid, 1);
    chk("commit_rhit", resp_hit, 0);
    chk("commit_memrd", mem_rd, 0);
    tick;
    chk("miss_done", done, 1);
    chk("miss_tag_end", tag_wr, 0);
    chk("miss_cnt", miss_cnt, 1);
    chk("miss_acc", acc_cnt, 3);

    // stray mem_valid and start in LOOKUP are ignored
    go_lookup;
    mem_valid = 1'b1; #1;
    chk("lk_memv_wr", wr_en, 0);
    start = 1'b1; tick;
    chk("lk_stray_ready", req_ready, 1);
    chk("lk_stray_memrd", mem_rd, 0);
    chk("lk_stray_wr", wr_en, 0);
    mem_valid = 1'b0; start = 1'b0; tick;
    chk("lk_still", req_ready, 1);
    req_valid = 1'b1; hit = 1'b1; req_last = 1'b1; req_addr = 15'h0020; tick;
    req_valid = 1'b0; req_last = 1'b0;
    chk("lk_end_done", done, 1);

    // request in IDLE is not accepted or counted
    req_valid = 1'b1; tick; tick;
    req_valid = 1'b0;
    chk("idle_req_acc", acc_cnt, 4);
    chk("idle_req_hit", hit_cnt, 3);

    // clear, then saturate at 15
    clr_stats = 1'b1; tick;
    clr_stats = 1'b0;
    chk("clr_acc", acc_cnt, 0);
    chk("clr_miss", miss_cnt, 0);
    go_lookup;
    req_valid = 1'b1; hit = 1'b1; req_last = 1'b0;
    for (int i = 0; i < 20; i++) begin
      req_addr = AW'(i); tick;
    end
    chk("sat_hit", hit_cnt, 15);
    chk("sat_acc", acc_cnt, 15);
    chk("sat_miss", miss_cnt, 0);
    clr_stats = 1'b1; req_last = 1'b1; tick;
    clr_stats = 1'b0; req_valid = 1'b0; req_last = 1'b0;
    chk("clrwin_acc", acc_cnt, 0);
    chk("clrwin_hit", hit_cnt, 0);
    chk("clrwin_done", done, 1);

    // reset mid-refill after the second beat
    go_lookup;
    req_valid = 1'b1; hit = 1'b0; req_addr = 15'h0040; req_last = 1'b0; tick;
    req_valid = 1'b0; hit = 1'b1;
    mem_valid = 1'b1; tick; tick;
    mem_valid = 1'b0;
    chk("mid_addr", mem_addr, 32'h0042);
    chk("mid_acc", acc_cnt, 1);
    rst_n = 1'b0; #1;
    chk("abort_done", done, 1);
    chk("abort_memrd", mem_rd, 0);
    chk("abort_memaddr", mem_addr, 0);
    chk("abort_tag", tag_wr, 0);
    chk("abort_acc", acc_cnt, 0);
    chk("abort_word", wr_word, 0);
    tick;
    rst_n = 1'b1;
    mem_valid = 1'b1; #1;
    chk("abort_stray_wr", wr_en, 0);
    tick;
    mem_valid = 1'b0;
    chk("abort_stray_done", done, 1);
    chk("abort_stray_tag", tag_wr, 0);

    // one-word line: single-beat refill
    b_start = 1'b1; tick;
    b_start = 1'b0; tick;
    b_req_valid = 1'b1; b_hit = 1'b0; b_req_addr = 15'h0005; b_req_last = 1'b1; tick;
    b_req_valid = 1'b0; b_req_last = 1'b0;
    chk("lw1_memrd", b_mem_rd, 1);
    chk("lw1_addr", b_mem_addr, 32'h0005);
    b_mem_valid = 1'b1; #1;
    chk("lw1_wr", b_wr_en, 1);
    chk("lw1_word", b_wr_word, 0);
    tick;
    b_mem_valid = 1'b0;
    chk("lw1_tag", b_tag_wr, 1);
    chk("lw1_resp", b_resp_valid, 1);
    chk("lw1_rhit", b_resp_hit, 0);
    tick;
    chk("lw1_done", b_done, 1);
    chk("lw1_miss", b_miss_cnt, 1);
    chk("lw1_hitcnt", b_hit_cnt, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
